// File: rtl/stream_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : stream_multiplexer
// Purpose  : Valid/ready N:1 stream mux, round-robin or fixed-priority
//            arbitration, packet lock until last, registered output stage.
// Revision : 1.0
// ============================================================================
module stream_multiplexer #(
    parameter int BUS_SIZE = 16,
    parameter int CH_COUNT = 16,
    parameter int IDX_SIZE = 4,
    parameter int MODE     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_SIZE*CH_COUNT-1:0] in_bus,
    input  logic [CH_COUNT-1:0]          in_valid,
    input  logic [CH_COUNT-1:0]          in_last,
    output logic [CH_COUNT-1:0]          in_ready,
    output logic [BUS_SIZE-1:0]          out_bus,
    output logic [IDX_SIZE-1:0]          out_index,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(CH_COUNT - 1);

    state_t              state;
    logic [IDX_SIZE-1:0] rr_ptr;
    logic [IDX_SIZE-1:0] lock_idx;
    logic [IDX_SIZE-1:0] arb_idx;
    logic                arb_found;
    logic [IDX_SIZE-1:0] grant;
    logic                grant_valid;
    logic [IDX_SIZE-1:0] next_ptr;
    logic                load;
    logic                take;
    logic [BUS_SIZE-1:0] sel_bus;
    logic                sel_last;

    // Candidate order is rotated by rr_ptr with an explicit wrap so that
    // non-power-of-two channel counts never produce an out-of-range index.
    always_comb begin
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (MODE == 1) begin
                cand = k;
            end else begin
                cand = int'(rr_ptr) + k;
                if (cand >= CH_COUNT) begin
                    cand = cand - CH_COUNT;
                end
            end
            if (!arb_found && in_valid[IDX_SIZE'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_SIZE'(cand);
            end
        end
    end

    always_comb begin
        if (state == LOCKED) begin
            grant       = lock_idx;
            grant_valid = in_valid[lock_idx];
        end else begin
            grant       = arb_idx;
            grant_valid = arb_found;
        end
    end

    assign load     = !out_valid || out_ready;
    assign take     = load && grant_valid && !rst;
    assign next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_bus  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (grant == IDX_SIZE'(i)) begin
                sel_bus  = in_bus[i*BUS_SIZE +: BUS_SIZE];
                sel_last = in_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_idx  <= '0;
            out_bus   <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (take) begin
                out_bus   <= sel_bus;
                out_index <= grant;
                out_last  <= sel_last;
                out_valid <= 1'b1;
                if (sel_last) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end else begin
                    state    <= LOCKED;
                    lock_idx <= grant;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_multiplexer
// Purpose  : Scoreboard bench for stream_multiplexer (5-ch round-robin and
//            4-ch fixed-priority instances).
// Revision : 1.0
// ============================================================================
module tb_stream_multiplexer;

    localparam int BW  = 8;
    localparam int RCH = 5;
    localparam int RIW = 3;
    localparam int FCH = 4;
    localparam int FIW = 2;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [BW*RCH-1:0] r_bus;
    logic [RCH-1:0]    r_valid;
    logic [RCH-1:0]    r_last;
    logic [RCH-1:0]    r_ready;
    logic [BW-1:0]     r_obus;
    logic [RIW-1:0]    r_oidx;
    logic              r_olast;
    logic              r_ovalid;
    logic              ds_ready;

    // Fixed-priority instance
    logic [BW*FCH-1:0] f_bus;
    logic [FCH-1:0]    f_valid;
    logic [FCH-1:0]    f_last;
    logic [FCH-1:0]    f_ready;
    logic [BW-1:0]     f_obus;
    logic [FIW-1:0]    f_oidx;
    logic              f_olast;
    logic              f_ovalid;
    logic              f_oready;

    stream_multiplexer #(.BUS_SIZE(BW), .CH_COUNT(RCH), .IDX_SIZE(RIW), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_bus(r_bus), .in_valid(r_valid), .in_last(r_last),
        .in_ready(r_ready), .out_bus(r_obus), .out_index(r_oidx), .out_last(r_olast),
        .out_valid(r_ovalid), .out_ready(ds_ready)
    );

    stream_multiplexer #(.BUS_SIZE(BW), .CH_COUNT(FCH), .IDX_SIZE(FIW), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_bus(f_bus), .in_valid(f_valid), .in_last(f_last),
        .in_ready(f_ready), .out_bus(f_obus), .out_index(f_oidx), .out_last(f_olast),
        .out_valid(f_ovalid), .out_ready(f_oready)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    beat_t       src_q [RCH][$];
    logic [16:0] exp_r[$];
    logic [16:0] exp_f[$];
    logic [RCH-1:0] acc;
    beat_t       pb;
    int          order [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [16:0] pk(input int idx, input logic [BW-1:0] d, input logic l);
        return {idx[7:0], d, l};
    endfunction

    function automatic bit src_busy();
        for (int c = 0; c < RCH; c++) if (src_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_beat(input int c, input logic [BW-1:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        src_q[c].push_back(b);
    endtask

    task automatic expect_r(input int c, input logic [BW-1:0] d, input logic l);
        exp_r.push_back(pk(c, d, l));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((src_busy() || exp_r.size() != 0) && n < 60) begin
            @(posedge clk); #3;
            n++;
        end
        check(name, 32'(n < 60), 32'd1);
    endtask

    // Upstream producers: a beat leaves its queue once seen accepted; a
    // non-zero gap withholds valid for that many cycles before the beat.
    initial begin
        r_valid = '0;
        r_bus   = '0;
        r_last  = '0;
        forever begin
            @(negedge clk);
            acc = r_valid & r_ready;
            @(posedge clk); #1;
            for (int c = 0; c < RCH; c++) begin
                if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                if (src_q[c].size() == 0) begin
                    r_valid[c] = 1'b0;
                end else begin
                    pb = src_q[c].pop_front();
                    if (pb.gap > 0) begin
                        r_valid[c] = 1'b0;
                        pb.gap     = pb.gap - 1;
                    end else begin
                        r_valid[c] = 1'b1;
                    end
                    r_bus[c*BW +: BW] = pb.data;
                    r_last[c]         = pb.last;
                    src_q[c].push_front(pb);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever an output transfer happens.
    always @(negedge clk) begin
        if (r_ovalid && ds_ready) begin
            if (exp_r.size() == 0) begin
                chk_cnt++;
                $display("FAIL rr_unexpected_beat: got 0x%0h expected none", pk(int'(r_oidx), r_obus, r_olast));
            end else begin
                check("rr_beat", 32'(pk(int'(r_oidx), r_obus, r_olast)), 32'(exp_r.pop_front()));
            end
        end
        if (f_ovalid && f_oready) begin
            if (exp_f.size() == 0) begin
                chk_cnt++;
                $display("FAIL fp_unexpected_beat: got 0x%0h expected none", pk(int'(f_oidx), f_obus, f_olast));
            end else begin
                check("fp_beat", 32'(pk(int'(f_oidx), f_obus, f_olast)), 32'(exp_f.pop_front()));
            end
        end
    end

    initial begin
        ds_ready = 1'b1;
        f_oready = 1'b1;
        f_valid  = '0;
        f_last   = '1;
        f_bus    = {8'h33, 8'h22, 8'h11, 8'h00};
        order    = '{3, 4, 0, 1, 2};

        // Channel 2 is valid during reset; it must not be readied until release.
        push_beat(2, 8'h2F, 1'b1, 0);
        expect_r(2, 8'h2F, 1'b1);
        #12;
        check("rst_out_valid", 32'(r_ovalid), 32'd0);
        check("rst_out_bus",   32'(r_obus),   32'd0);
        check("rst_out_index", 32'(r_oidx),   32'd0);
        check("rst_out_last",  32'(r_olast),  32'd0);
        check("rst_in_ready",  32'(r_ready),  32'd0);
        check("rst_fp_valid",  32'(f_ovalid), 32'd0);
        #5 rst = 1'b0;

        // Fixed priority: channels 1 and 3 valid, then channel 1 drops.
        @(posedge clk); #1;
        f_valid = 4'b1010;
        repeat (6) exp_f.push_back(pk(1, 8'h11, 1'b1));
        repeat (6) @(posedge clk);
        #1 f_valid = 4'b1000;
        repeat (4) exp_f.push_back(pk(3, 8'h33, 1'b1));
        repeat (4) @(posedge clk);
        #1 f_valid = 4'b0000;
        repeat (3) @(posedge clk);
        check("fp_drain", 32'(exp_f.size()), 32'd0);
        wait_drain("first_grant_drain");

        // Round-robin single beats; pointer is 3 after channel 2 was served.
        for (int c = 0; c < RCH; c++)
            for (int k = 0; k < 2; k++) push_beat(c, 8'(c*16 + k), 1'b1, 0);
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 5; j++) expect_r(order[j], 8'(order[j]*16 + k), 1'b1);
        wait_drain("rr_drain");

        // Packet lock: channel 1 moves the pointer to 2, then channel 2 packet
        // with a mid-packet stall while channel 0 waits.
        push_beat(1, 8'h1A, 1'b1, 0);
        expect_r(1, 8'h1A, 1'b1);
        wait_drain("pre_lock_drain");
        push_beat(2, 8'h20, 1'b0, 0);
        push_beat(2, 8'h21, 1'b0, 0);
        push_beat(2, 8'h22, 1'b0, 4);
        push_beat(2, 8'h23, 1'b1, 0);
        push_beat(0, 8'h0A, 1'b1, 0);
        expect_r(2, 8'h20, 1'b0);
        expect_r(2, 8'h21, 1'b0);
        expect_r(2, 8'h22, 1'b0);
        expect_r(2, 8'h23, 1'b1);
        expect_r(0, 8'h0A, 1'b1);
        wait_drain("lock_drain");

        // Backpressure with a held beat on channel 3.
        ds_ready = 1'b0;
        push_beat(3, 8'h30, 1'b1, 0);
        push_beat(3, 8'h31, 1'b1, 0);
        push_beat(3, 8'h32, 1'b1, 0);
        expect_r(3, 8'h30, 1'b1);
        expect_r(3, 8'h31, 1'b1);
        expect_r(3, 8'h32, 1'b1);
        for (int n = 0; n < 10 && !r_ovalid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            check("bp_valid", 32'(r_ovalid), 32'd1);
            check("bp_bus",   32'(r_obus),   32'h30);
            check("bp_index", 32'(r_oidx),   32'd3);
            check("bp_ready", 32'(r_ready),  32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 ds_ready = 1'b1;
        wait_drain("bp_drain");

        // Async reset while locked on channel 1 (stalled before its third beat).
        push_beat(1, 8'h14, 1'b0, 0);
        push_beat(1, 8'h15, 1'b0, 0);
        push_beat(1, 8'h16, 1'b0, 30);
        push_beat(1, 8'h17, 1'b1, 0);
        expect_r(1, 8'h14, 1'b0);
        expect_r(1, 8'h15, 1'b0);
        for (int n = 0; n < 20 && exp_r.size() != 0; n++) begin
            @(posedge clk); #3;
        end
        check("pre_reset_beats", 32'(exp_r.size()), 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(r_ovalid), 32'd0);
        check("arst_out_bus",   32'(r_obus),   32'd0);
        check("arst_out_index", 32'(r_oidx),   32'd0);
        check("arst_in_ready",  32'(r_ready),  32'd0);
        @(posedge clk); #2;
        for (int c = 0; c < RCH; c++) src_q[c].delete();
        exp_r.delete();
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;

        // Pointer back at 0: channel 3 beats channel 4; lock must be gone.
        push_beat(4, 8'h4A, 1'b1, 0);
        push_beat(3, 8'h3A, 1'b1, 0);
        expect_r(3, 8'h3A, 1'b1);
        expect_r(4, 8'h4A, 1'b1);
        wait_drain("post_reset_drain");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_multiplexer.md
# stream_multiplexer

Parametrised, handshaked successor to the combinational bus multiplexer. It arbitrates among `CH_COUNT` valid/ready input streams and forwards one beat per cycle through a registered output stage, tagging each beat with its source channel index. Arbitration is round-robin or fixed-priority, and multi-beat packets are locked to one channel until `last`. It sits between producer blocks and a shared downstream bus.

## Interface
- `BUS_SIZE`, 16: data width per channel, ≥1.
- `CH_COUNT`, 16: number of input channels, 2..256.
- `IDX_SIZE`, 4: index width; must equal max(1, $clog2(CH_COUNT)).
- `MODE`, 0: arbitration mode. 0 = round-robin, 1 = fixed priority (lowest index wins).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_bus`  in  BUS_SIZE*CH_COUNT  channel i data at bits [i*BUS_SIZE +: BUS_SIZE].
- `in_valid`  in  CH_COUNT  per-channel valid.
- `in_last`  in  CH_COUNT  per-channel end-of-packet flag.
- `in_ready`  out  CH_COUNT  per-channel ready; one-hot or zero.
- `out_bus`  out  BUS_SIZE  registered data.
- `out_index`  out  IDX_SIZE  source channel of `out_bus`.
- `out_last`  out  1  registered last flag.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream ready.

## Operation
- **Transfer rule.** A transfer occurs on a channel or on the output when valid && ready at a rising edge.
- **Output register.** A single-entry register holds (bus, index, last).
  - `load` = !out_valid || out_ready.
  - `in_ready[g]` = load && in_valid[g], where g is the current grant. All other `in_ready` bits are 0.
  - On an input transfer the register loads, and `out_valid` is 1 the next cycle.
  - If there is an output transfer and no input transfer, `out_valid` goes to 0.
- **State machine.**
  - IDLE: g = the winner among the asserted `in_valid` bits.
    - MODE 0: search starts at `rr_ptr` and goes upward, wrapping from CH_COUNT-1 to 0.
    - MODE 1: lowest asserted index wins.
    - If no `in_valid` bit is set, there is no grant and no `in_ready`.
  - IDLE → LOCKED: on an input transfer with `in_last` = 0. `lock_idx` captures g.
  - IDLE, transfer with `in_last` = 1: single-beat packet; state stays IDLE.
  - LOCKED: g = `lock_idx` regardless of other valids. `in_ready` is given only to `lock_idx`.
  - LOCKED → IDLE: on an input transfer with `in_last` = 1.
  - LOCKED, `in_valid[lock_idx]` = 0: wait; no other channel is served.
- **Pointer.** On each packet completion (input transfer with `in_last` = 1), `rr_ptr` ← (g+1) mod CH_COUNT. Wrap is explicit for non-power-of-two CH_COUNT. In MODE 1 the pointer is maintained but unused.
- **Stability.** Upstream must hold data and last while valid && !ready. The block does not rely on this for correctness of its own state.
- **Index range.** Indices ≥ CH_COUNT never appear on `out_index`.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`. Sustained throughput is 1 beat/cycle while `out_ready` = 1.
- Simultaneous output transfer and input transfer: the register reloads in the same edge; no bubble.
- With `out_ready` = 0 and `out_valid` = 1: all `in_ready` bits are 0. The register, state and pointer hold.
- Arbitration and `in_ready` are combinational from `in_valid`, state, pointer, `out_valid` and `out_ready`. There is no combinational path from `in_bus` to any output.
- Reset values (async; held while `rst` = 1):
  - `out_valid` = 0, `out_bus` = 0, `out_index` = 0, `out_last` = 0.
  - State = IDLE, `rr_ptr` = 0, `lock_idx` = 0.
  - `in_ready` forced to 0 while `rst` = 1.
- Reset mid-packet drops the lock and any held beat; there is no partial-packet recovery.
- First grant is possible in the first cycle after reset deassertion.

## Test plan
- **Round-robin single-beat.** MODE 0, CH_COUNT = 4, all valid, last = 1, `out_ready` = 1 → `out_index` sequence 0,1,2,3,0,…; one beat per cycle after 1-cycle latency.
- **Fixed priority.** MODE 1, channels 1 and 3 valid continuously → only channel 1 served. Drop channel 1 → channel 3 granted the next cycle.
- **Packet lock.** Channel 2 sends 4 beats (last on beat 4) while channel 0 is valid → beats 1–4 all carry `out_index` = 2 contiguously. Channel 0 served next and `rr_ptr` = 3. Stall channel 2 valid mid-packet → no other grant.
- **Backpressure.** `out_ready` = 0 for 5 cycles with a beat held → `out_bus`, `out_index`, `out_last` stable and `in_ready` = 0. Release → no beats lost or duplicated against a scoreboard.
- **Non-power-of-two wrap.** CH_COUNT = 5: grant after channel 4 completes is channel 0. `out_index` never ≥ 5.
- **Async reset mid-packet.** Assert `rst` between clock edges during a LOCKED packet → outputs take reset values immediately. After release the lowest index at or after pointer 0 wins.
